// File: rtl/vga_scan_controller.sv
// VGA 640x480@60 scan controller: pixel-rate divider, scan counters, sync/blank
// generation and a registered RGB pin stage. Define VGA_TEST_PATTERN_EN for colour bars.
module vga_scan_controller #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_valid,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vga_red,
    output logic [3:0] vga_green,
    output logic [3:0] vga_blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic [3:0]       red_q, green_q, blue_q;
    logic             hsync_q, vsync_q;

    logic             tick;
    logic             h_last;
    logic             v_last;
    logic             active;
    logic             hsync_d;
    logic             vsync_d;
    logic [3:0]       red_src, green_src, blue_src;

    assign tick   = (div_q == DIV_LAST);
    assign h_last = (h_q == H_LAST);
    assign v_last = (v_q == V_LAST);
    assign active = (h_q < H_VIS) && (v_q < V_VIS);

    // Sync levels are computed from the pre-advance counters so they land on the
    // pins in the same pixel period as that coordinate's colour.
    assign hsync_d = !((h_q >= HS_START) && (h_q < HS_END));
    assign vsync_d = !((v_q >= VS_START) && (v_q < VS_END));

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

    logic [9:0] bar_idx;
    logic       unused_colour_in;

    assign bar_idx          = h_q / BAR_W;
    assign red_src          = {4{bar_idx[0]}};
    assign green_src        = {4{bar_idx[1]}};
    assign blue_src         = {4{bar_idx[2]}};
    assign unused_colour_in = ^{red_in, green_in, blue_in, bar_idx[9:3]};
`else
    assign red_src   = red_in;
    assign green_src = green_in;
    assign blue_src  = blue_in;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned; a missing default here would infer a latch.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            div_d = '0;
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            if (tick) begin
                red_q   <= active ? red_src   : 4'h0;
                green_q <= active ? green_src : 4'h0;
                blue_q  <= active ? blue_src  : 4'h0;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
            end
        end
    end

    assign pix_x       = h_q;
    assign pix_y       = v_q;
    assign pix_valid   = active;
    assign pix_tick    = tick;
    assign frame_start = tick && h_last && v_last;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vga_red     = red_q;
    assign vga_green   = green_q;
    assign vga_blue    = blue_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench: full-size instance for line timing/colour/reset, reduced instance for frame timing.
module tb_vga_scan_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst_s;
    logic [3:0] red_in, green_in, blue_in;
    logic [3:0] s_red_in, s_green_in, s_blue_in;

    logic [9:0] m_x, m_y, s_x, s_y;
    logic       m_valid, m_tick, m_frame, m_hs, m_vs;
    logic       s_valid, s_tick, s_frame, s_hs, s_vs;
    logic [3:0] m_r, m_g, m_b, s_r, s_g, s_b;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    vga_scan_controller dut (
        .clk_100mhz(clk), .rst(rst),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .pix_x(m_x), .pix_y(m_y), .pix_valid(m_valid), .pix_tick(m_tick),
        .frame_start(m_frame), .hsync(m_hs), .vsync(m_vs),
        .vga_red(m_r), .vga_green(m_g), .vga_blue(m_b)
    );

    // Reduced timing: H_TOTAL=16, V_TOTAL=8, so a frame is 512 clocks.
    vga_scan_controller #(
        .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .clk_100mhz(clk), .rst(rst_s),
        .red_in(s_red_in), .green_in(s_green_in), .blue_in(s_blue_in),
        .pix_x(s_x), .pix_y(s_y), .pix_valid(s_valid), .pix_tick(s_tick),
        .frame_start(s_frame), .hsync(s_hs), .vsync(s_vs),
        .vga_red(s_r), .vga_green(s_g), .vga_blue(s_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to cycle k after reset release, sampling 1ns after the edge.
    task automatic goto(input int k);
        repeat (k - cyc) @(posedge clk);
        #1;
        cyc = k;
    endtask

    function automatic logic [11:0] exp_rgb(input int x, input int y, input int ha, input int va,
                                            input logic [3:0] r, input logic [3:0] g,
                                            input logic [3:0] b);
        int bar;
        if (x >= ha || y >= va) return 12'h000;
`ifdef VGA_TEST_PATTERN_EN
        bar = x / (ha / 8);
        return {(bar % 2 == 1) ? 4'hF : 4'h0,
                ((bar / 2) % 2 == 1) ? 4'hF : 4'h0,
                ((bar / 4) % 2 == 1) ? 4'hF : 4'h0};
`else
        bar = 0;
        return {r, g, b};
`endif
    endfunction

    initial begin
        rst = 1'b1;
        rst_s = 1'b1;
        red_in = 4'hF; green_in = 4'h0; blue_in = 4'h0;
        s_red_in = 4'h0; s_green_in = 4'h0; s_blue_in = 4'h0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_tick", m_tick, 0);
        check("rst_x", m_x, 0);
        check("rst_y", m_y, 0);
        check("rst_valid", m_valid, 1);
        check("rst_hsync", m_hs, 1);
        check("rst_vsync", m_vs, 1);
        check("rst_rgb", {m_r, m_g, m_b}, 0);
        check("rst_frame", m_frame, 0);
        rst = 1'b0;
        cyc = 0;

        // First tick and first registered pixel
        goto(2);
        check("pre_tick", m_tick, 0);
        check("pre_tick_rgb", {m_r, m_g, m_b}, 0);
        goto(3);
        check("first_tick", m_tick, 1);
        check("first_tick_x", m_x, 0);
        goto(4);
        check("tick_drop", m_tick, 0);
        check("x_after_tick", m_x, 1);
        check("rgb_px0", {m_r, m_g, m_b}, exp_rgb(0, 0, 640, 480, 4'hF, 4'h0, 4'h0));
        goto(7);
        check("second_tick", m_tick, 1);
        goto(324);
        check("rgb_px80", {m_r, m_g, m_b}, exp_rgb(80, 0, 640, 480, 4'hF, 4'h0, 4'h0));
        goto(2244);
        check("rgb_px560", {m_r, m_g, m_b}, exp_rgb(560, 0, 640, 480, 4'hF, 4'h0, 4'h0));

        // Active/blank boundary
        goto(2559);
        check("x639", m_x, 639);
        check("valid639", m_valid, 1);
        goto(2560);
        check("x640", m_x, 640);
        check("valid640", m_valid, 0);
        check("rgb_px639", {m_r, m_g, m_b}, exp_rgb(639, 0, 640, 480, 4'hF, 4'h0, 4'h0));
        goto(2564);
        check("rgb_px640_blank", {m_r, m_g, m_b}, 0);

        // hsync window: low from tick sampling h=656 to tick sampling h=752
        goto(2627);
        check("hs_before", m_hs, 1);
        goto(2628);
        check("hs_start", m_hs, 0);
        goto(3011);
        check("hs_last_low", m_hs, 0);
        goto(3012);
        check("hs_end", m_hs, 1);

        // Line wrap
        goto(3199);
        check("x799", m_x, 799);
        check("tick799", m_tick, 1);
        check("no_frame_line0", m_frame, 0);
        goto(3200);
        check("wrap_x", m_x, 0);
        check("wrap_y", m_y, 1);
        check("wrap_valid", m_valid, 1);
        check("rgb_px799_blank", {m_r, m_g, m_b}, 0);
        goto(3204);
        check("rgb_line1_px0", {m_r, m_g, m_b}, exp_rgb(0, 1, 640, 480, 4'hF, 4'h0, 4'h0));

        // Mid-line, mid-pixel reset at x=300 of line 1
        goto(4401);
        check("x300", m_x, 300);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_x", m_x, 0);
        check("mid_rst_y", m_y, 0);
        check("mid_rst_tick", m_tick, 0);
        check("mid_rst_rgb", {m_r, m_g, m_b}, 0);
        check("mid_rst_hsync", m_hs, 1);
        rst = 1'b0;
        cyc = 0;

        // Different input pattern after restart
        red_in = 4'h3; green_in = 4'h7; blue_in = 4'h9;
        goto(3);
        check("restart_tick", m_tick, 1);
        goto(4);
        check("rgb_379", {m_r, m_g, m_b}, exp_rgb(0, 0, 640, 480, 4'h3, 4'h7, 4'h9));

        // Reset during hsync pulse forces hsync high
        goto(2801);
        check("hs_low_x700", m_hs, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("hs_rst_hsync", m_hs, 1);
        check("hs_rst_x", m_x, 0);

        // Reduced-size instance: vertical timing and frame_start
        rst_s = 1'b0;
        cyc = 0;
        goto(24);
        check("s_rgb_px5", {s_r, s_g, s_b}, exp_rgb(5, 0, 8, 4, 4'h0, 4'h0, 4'h0));
        goto(40);
        check("s_rgb_px9_blank", {s_r, s_g, s_b}, 0);
        goto(43);
        check("s_hs_before", s_hs, 1);
        goto(44);
        check("s_hs_start", s_hs, 0);
        goto(55);
        check("s_hs_last_low", s_hs, 0);
        goto(56);
        check("s_hs_end", s_hs, 1);
        goto(256);
        check("s_y4", s_y, 4);
        check("s_y4_valid", s_valid, 0);
        goto(323);
        check("s_vs_before", s_vs, 1);
        check("s_y5", s_y, 5);
        goto(324);
        check("s_vs_start", s_vs, 0);
        goto(451);
        check("s_vs_last_low", s_vs, 0);
        goto(452);
        check("s_vs_end", s_vs, 1);
        goto(510);
        check("s_frame_early", s_frame, 0);
        goto(511);
        check("s_frame_pulse", s_frame, 1);
        check("s_frame_x", s_x, 15);
        check("s_frame_y", s_y, 7);
        goto(512);
        check("s_frame_drop", s_frame, 0);
        check("s_frame_wrap_x", s_x, 0);
        check("s_frame_wrap_y", s_y, 0);
        goto(1023);
        check("s_frame_pulse2", s_frame, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
